// File: rtl/four_way_rr_arbiter_if.sv
// four_way_rr_arbiter_if: requester/consumer bundle between producers, arbiter and downstream
interface four_way_rr_arbiter_if #(parameter int WIDTH = 1);
  logic [3:0]       req;
  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic [WIDTH-1:0] i2;
  logic [WIDTH-1:0] i3;
  logic             ready;
  logic [3:0]       grant;
  logic [1:0]       sel;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             busy;
  modport slave (input req, i0, i1, i2, i3, ready, output grant, sel, out, out_valid, busy);
  modport master (output req, i0, i1, i2, i3, ready, input grant, sel, out, out_valid, busy);
endinterface

// File: rtl/four_way_rr_arbiter.sv
// four_way_rr_arbiter: round-robin owner of a 4:1 selector with bounded grant length
module four_way_rr_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input logic                  clk,
  input logic                  reset,
  four_way_rr_arbiter_if.slave bus
);
  localparam int HW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
  typedef enum logic {IDLE, GRANT} state_t;
  state_t           state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       last_q, last_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [1:0]       base, win;
  logic             found, valid, xfer, rel;
  logic [WIDTH-1:0] word;
  // first requester after base in rotating order; base itself is considered last
  always_comb begin
    base  = (state_q == GRANT) ? sel_q : last_q;
    win   = base;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!found && bus.req[base + 2'(k)]) begin
        win   = base + 2'(k);
        found = 1'b1;
      end
    end
  end
  // handshake and release conditions for the current owner
  always_comb begin
    valid = (state_q == GRANT) && bus.req[sel_q];
    xfer  = valid && bus.ready;
    rel   = (state_q == GRANT) && (!bus.req[sel_q] || (xfer && hold_q == HW'(MAX_HOLD - 1)));
  end
  // next grant: arbitrate from idle or on release with no bubble, otherwise count transfers
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    last_d  = rel ? sel_q : last_q;
    hold_d  = hold_q;
    if ((state_q == IDLE || rel) && found) begin
      state_d = GRANT;
      grant_d = 4'b0001 << win;
      sel_d   = win;
      hold_d  = '0;
    end else if (rel) begin
      state_d = IDLE;
      grant_d = '0;
      hold_d  = '0;
    end else if (xfer) begin
      hold_d = hold_q + 1'b1;
    end
  end
  // state registers; last resets to 3 so requester 0 wins first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      last_q  <= 2'b11;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end
  // data selector driven by the registered select
  always_comb begin
    word = sel_q == 2'd0 ? bus.i0 : sel_q == 2'd1 ? bus.i1 : sel_q == 2'd2 ? bus.i2 : bus.i3;
  end
  assign bus.out       = word;
  assign bus.out_valid = valid;
  assign bus.grant     = grant_q;
  assign bus.sel       = sel_q;
  assign bus.busy      = (state_q == GRANT);
endmodule
